mshr_coalesce: RTL and testbench

Parametrised miss-status holding register for the cache miss path, successor to the fixed 8-entry MSHR. It holds 2^TAG_BITS outstanding misses, hands unissued misses to the memory side in allocation order, and is released by tag when the fill returns. On top of the older block, it merges a secondary miss to an address that already has an entry: the requesting CPU is recorded in that entry's waiter mask instead of taking a new slot. It also reports occupancy and the waiter mask on release.

---
 rtl/mshr_coalesce.sv | 189 ++++++++++++++++++
 tb/tb_mshr_coalesce.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mshr_coalesce.sv
// Miss-status holding register with secondary-miss coalescing: allocates misses,
// issues them oldest-first, merges repeat addresses into a waiter mask, releases by tag.
module mshr_coalesce #(
  parameter int ADDR_BITS   = 20,
  parameter int DATA_BITS   = 90,
  parameter int TAG_BITS    = 3,
  parameter int CPU_ID_BITS = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         add,
  input  logic [ADDR_BITS-1:0]         add_addr,
  input  logic [DATA_BITS-1:0]         add_data,
  input  logic                         add_rw,
  input  logic                         add_dirty,
  input  logic [CPU_ID_BITS-1:0]       add_cpu_id,
  output logic                         add_ack,
  output logic                         add_merged,
  output logic [TAG_BITS-1:0]          add_tag,
  input  logic                         del,
  input  logic [TAG_BITS-1:0]          del_tag,
  output logic                         del_valid,
  output logic [(1<<CPU_ID_BITS)-1:0]  del_waiters,
  input  logic                         read_next,
  output logic                         rn_valid,
  output logic [ADDR_BITS-1:0]         rn_addr,
  output logic [DATA_BITS-1:0]         rn_data,
  output logic                         rn_rw,
  output logic                         rn_dirty,
  output logic [CPU_ID_BITS-1:0]       rn_cpu_id,
  output logic [TAG_BITS-1:0]          rn_tag,
  input  logic                         get,
  input  logic [TAG_BITS-1:0]          get_tag,
  output logic                         get_valid,
  output logic [ADDR_BITS-1:0]         get_addr,
  output logic [DATA_BITS-1:0]         get_data,
  output logic                         get_rw,
  output logic                         get_dirty,
  output logic [CPU_ID_BITS-1:0]       get_cpu_id,
  output logic [(1<<CPU_ID_BITS)-1:0]  get_waiters,
  output logic                         empty,
  output logic                         full,
  output logic [TAG_BITS:0]            count
);

  localparam int DEPTH = 1 << TAG_BITS;
  localparam int NCPU  = 1 << CPU_ID_BITS;

  logic [DEPTH-1:0]       valid_q, valid_d, issued_q, issued_d;
  logic [DEPTH-1:0]       rw_q, rw_d, dirty_q, dirty_d;
  logic [ADDR_BITS-1:0]   addr_q [DEPTH];
  logic [ADDR_BITS-1:0]   addr_d [DEPTH];
  logic [DATA_BITS-1:0]   data_q [DEPTH];
  logic [DATA_BITS-1:0]   data_d [DEPTH];
  logic [CPU_ID_BITS-1:0] cpu_q  [DEPTH];
  logic [CPU_ID_BITS-1:0] cpu_d  [DEPTH];
  logic [NCPU-1:0]        wait_q [DEPTH];
  logic [NCPU-1:0]        wait_d [DEPTH];
  // older_q[i][j] is set when entry i was allocated before entry j
  logic [DEPTH-1:0]       older_q [DEPTH];
  logic [DEPTH-1:0]       older_d [DEPTH];

  logic [DEPTH-1:0]    del_hit_s, match_s, pend_s, oldest_s, alloc_s, merge_s;
  logic [TAG_BITS-1:0] hit_tag_s, free_tag_s, rn_tag_s;
  logic [TAG_BITS:0]   cnt_s;
  logic                hit_s, ack_s, rn_fire_s;
  logic [NCPU-1:0]     onehot_s;

  assign full     = &valid_q;
  assign empty    = ~|valid_q;
  assign onehot_s = {{(NCPU-1){1'b0}}, 1'b1} << add_cpu_id;

  // Lookup: address match, free slot, oldest unissued entry, occupancy and edge strobes
  always_comb begin
    del_hit_s  = '0;
    match_s    = '0;
    oldest_s   = '0;
    alloc_s    = '0;
    hit_tag_s  = '0;
    free_tag_s = '0;
    rn_tag_s   = '0;
    cnt_s      = '0;
    pend_s     = valid_q & ~issued_q;
    for (int i = 0; i < DEPTH; i++) begin
      del_hit_s[i] = enable && del && (del_tag == TAG_BITS'(i)) && valid_q[i];
      match_s[i]   = valid_q[i] && !del_hit_s[i] && (addr_q[i] == add_addr);
      hit_tag_s    = match_s[i] ? TAG_BITS'(i) : hit_tag_s;
      cnt_s        = cnt_s + (TAG_BITS+1)'(valid_q[i]);
      oldest_s[i]  = pend_s[i];
      for (int j = 0; j < DEPTH; j++) begin
        oldest_s[i] = oldest_s[i] && !(pend_s[j] && older_q[j][i]);
      end
      rn_tag_s = oldest_s[i] ? TAG_BITS'(i) : rn_tag_s;
    end
    for (int i = DEPTH-1; i >= 0; i--) begin
      free_tag_s = !valid_q[i] ? TAG_BITS'(i) : free_tag_s;
    end
    hit_s     = |match_s;
    ack_s     = enable && add && (hit_s || !full);
    rn_fire_s = enable && read_next && (|oldest_s);
    merge_s   = ack_s ? match_s : '0;
    for (int i = 0; i < DEPTH; i++) begin
      alloc_s[i] = ack_s && !hit_s && (free_tag_s == TAG_BITS'(i));
    end
  end

  // Next state of every entry from the allocate/merge/issue/release strobes
  always_comb begin
    valid_d  = valid_q;
    issued_d = issued_q;
    rw_d     = rw_q;
    dirty_d  = dirty_q;
    addr_d   = addr_q;
    data_d   = data_q;
    cpu_d    = cpu_q;
    wait_d   = wait_q;
    older_d  = older_q;
    for (int i = 0; i < DEPTH; i++) begin
      valid_d[i]  = (valid_q[i] && !del_hit_s[i]) || alloc_s[i];
      issued_d[i] = (issued_q[i] || (rn_fire_s && (rn_tag_s == TAG_BITS'(i)))) && !alloc_s[i];
      if (alloc_s[i]) begin
        addr_d[i]  = add_addr;
        data_d[i]  = add_data;
        rw_d[i]    = add_rw;
        dirty_d[i] = add_dirty;
        cpu_d[i]   = add_cpu_id;
        wait_d[i]  = onehot_s;
      end else if (merge_s[i]) begin
        wait_d[i]  = wait_q[i] | onehot_s;
        dirty_d[i] = dirty_q[i] | add_dirty;
        // once issued, the memory request already carries the old payload
        if (add_rw && !issued_q[i]) begin
          data_d[i] = add_data;
          rw_d[i]   = 1'b1;
        end else begin
          data_d[i] = data_q[i];
        end
      end else begin
        wait_d[i] = wait_q[i];
      end
      for (int j = 0; j < DEPTH; j++) begin
        older_d[i][j] = alloc_s[j] ? (i != j) : (alloc_s[i] ? 1'b0 : older_q[i][j]);
      end
    end
  end

  // State registers; reset only needs to drop valid and issued
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= '0;
      issued_q <= '0;
    end else begin
      valid_q  <= valid_d;
      issued_q <= issued_d;
      rw_q     <= rw_d;
      dirty_q  <= dirty_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      cpu_q    <= cpu_d;
      wait_q   <= wait_d;
      older_q  <= older_d;
    end
  end

  assign count       = cnt_s;
  assign add_ack     = ack_s;
  assign add_merged  = ack_s && hit_s;
  assign add_tag     = hit_s ? hit_tag_s : free_tag_s;
  assign del_valid   = |del_hit_s;
  assign del_waiters = wait_q[del_tag];

  assign rn_valid    = |oldest_s;
  assign rn_tag      = rn_tag_s;
  assign rn_addr     = addr_q[rn_tag_s];
  assign rn_data     = data_q[rn_tag_s];
  assign rn_rw       = rw_q[rn_tag_s];
  assign rn_dirty    = dirty_q[rn_tag_s];
  assign rn_cpu_id   = cpu_q[rn_tag_s];

  assign get_valid   = get && valid_q[get_tag];
  assign get_addr    = addr_q[get_tag];
  assign get_data    = data_q[get_tag];
  assign get_rw      = rw_q[get_tag];
  assign get_dirty   = dirty_q[get_tag];
  assign get_cpu_id  = cpu_q[get_tag];
  assign get_waiters = wait_q[get_tag];

endmodule

// File: tb/tb_mshr_coalesce.sv
// Directed bench for mshr_coalesce: allocation, merge, issue order, release, full, enable and reset.
module tb_mshr_coalesce;

  localparam int AB = 20;
  localparam int DB = 90;
  localparam int TB = 3;
  localparam int CB = 2;

  logic          clk = 1'b0;
  logic          reset, enable, add, add_rw, add_dirty;
  logic [AB-1:0] add_addr;
  logic [DB-1:0] add_data;
  logic [CB-1:0] add_cpu_id;
  logic          add_ack, add_merged;
  logic [TB-1:0] add_tag;
  logic          del, del_valid;
  logic [TB-1:0] del_tag;
  logic [3:0]    del_waiters;
  logic          read_next, rn_valid, rn_rw, rn_dirty;
  logic [AB-1:0] rn_addr;
  logic [DB-1:0] rn_data;
  logic [CB-1:0] rn_cpu_id;
  logic [TB-1:0] rn_tag;
  logic          get, get_valid, get_rw, get_dirty;
  logic [TB-1:0] get_tag;
  logic [AB-1:0] get_addr;
  logic [DB-1:0] get_data;
  logic [CB-1:0] get_cpu_id;
  logic [3:0]    get_waiters;
  logic          empty, full;
  logic [TB:0]   count;

  int total = 0;
  int bad   = 0;
  logic [TB-1:0] fill_tags [6];

  always #5 clk = ~clk;

  mshr_coalesce dut (
    .clk(clk), .reset(reset), .enable(enable),
    .add(add), .add_addr(add_addr), .add_data(add_data), .add_rw(add_rw),
    .add_dirty(add_dirty), .add_cpu_id(add_cpu_id),
    .add_ack(add_ack), .add_merged(add_merged), .add_tag(add_tag),
    .del(del), .del_tag(del_tag), .del_valid(del_valid), .del_waiters(del_waiters),
    .read_next(read_next), .rn_valid(rn_valid), .rn_addr(rn_addr), .rn_data(rn_data),
    .rn_rw(rn_rw), .rn_dirty(rn_dirty), .rn_cpu_id(rn_cpu_id), .rn_tag(rn_tag),
    .get(get), .get_tag(get_tag), .get_valid(get_valid), .get_addr(get_addr),
    .get_data(get_data), .get_rw(get_rw), .get_dirty(get_dirty),
    .get_cpu_id(get_cpu_id), .get_waiters(get_waiters),
    .empty(empty), .full(full), .count(count)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    add = 1'b0; add_addr = '0; add_data = '0; add_rw = 1'b0; add_dirty = 1'b0; add_cpu_id = '0;
    del = 1'b0; del_tag = '0; read_next = 1'b0; get = 1'b0; get_tag = '0;
  endtask

  task automatic put(input int a, input int cpu, input logic rw, input logic dty, input int d);
    add = 1'b1; add_addr = AB'(a); add_cpu_id = CB'(cpu); add_rw = rw; add_dirty = dty; add_data = DB'(d);
  endtask

  initial begin
    fill_tags[0] = 3'd0; fill_tags[1] = 3'd3; fill_tags[2] = 3'd4;
    fill_tags[3] = 3'd5; fill_tags[4] = 3'd6; fill_tags[5] = 3'd7;
    idle(); reset = 1'b1; enable = 1'b1;
    tick(); tick();
    reset = 1'b0; get = 1'b1; get_tag = 3'd0; #1;
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_count", count, 4'd0);
    chk("rst_rn_valid", rn_valid, 1'b0);
    chk("rst_get_valid", get_valid, 1'b0);

    // three primary misses
    for (int k = 0; k < 3; k++) begin
      idle(); put(90 + k, k, 1'b0, 1'b0, 1090 + k); #1;
      chk("alloc_ack", add_ack, 1'b1);
      chk("alloc_merged", add_merged, 1'b0);
      chk("alloc_tag", add_tag, TB'(k));
      tick();
    end
    idle(); #1;
    chk("three_count", count, 4'd3);
    chk("three_rn_addr", rn_addr, 20'd90);
    chk("three_rn_tag", rn_tag, 3'd0);

    // secondary miss on 91 from cpu 3 with a write payload
    put(91, 3, 1'b1, 1'b1, 32'hABC); #1;
    chk("merge_ack", add_ack, 1'b1);
    chk("merge_flag", add_merged, 1'b1);
    chk("merge_tag", add_tag, 3'd1);
    tick(); idle(); get = 1'b1; get_tag = 3'd1; #1;
    chk("merge_count", count, 4'd3);
    chk("merge_get_waiters", get_waiters, 4'b1010);
    chk("merge_get_data", get_data, 90'hABC);
    chk("merge_get_rw", get_rw, 1'b1);
    chk("merge_get_dirty", get_dirty, 1'b1);
    chk("merge_get_cpu", get_cpu_id, 2'd1);

    del = 1'b1; del_tag = 3'd1; #1;
    chk("del1_valid", del_valid, 1'b1);
    chk("del1_waiters", del_waiters, 4'b1010);
    tick(); idle(); #1;
    chk("del1_count", count, 4'd2);

    // re-allocation into slot 1 is the youngest entry
    put(93, 1, 1'b0, 1'b0, 1093); #1;
    chk("realloc_tag", add_tag, 3'd1);
    tick(); idle();
    read_next = 1'b1; #1;
    chk("issue0_addr", rn_addr, 20'd90);
    tick(); idle(); #1;
    chk("issue1_addr", rn_addr, 20'd92);
    chk("issue1_tag", rn_tag, 3'd2);
    read_next = 1'b1; tick(); idle(); #1;
    chk("issue2_addr", rn_addr, 20'd93);
    chk("issue2_tag", rn_tag, 3'd1);
    del = 1'b1; del_tag = 3'd0; #1;
    chk("del0_valid", del_valid, 1'b1);
    tick(); idle(); #1;
    chk("del0_rn_tag", rn_tag, 3'd1);
    chk("del0_count", count, 4'd2);
    read_next = 1'b1; tick(); idle(); #1;
    chk("drained_rn_valid", rn_valid, 1'b0);

    // merge into an issued entry keeps data and rw
    put(92, 3, 1'b1, 1'b0, 5555); #1;
    chk("merge_iss_flag", add_merged, 1'b1);
    chk("merge_iss_tag", add_tag, 3'd2);
    tick(); idle(); get = 1'b1; get_tag = 3'd2; #1;
    chk("merge_iss_data", get_data, 90'd1092);
    chk("merge_iss_rw", get_rw, 1'b0);
    chk("merge_iss_waiters", get_waiters, 4'b1100);

    // fill remaining six slots, lowest free index first
    for (int k = 0; k < 6; k++) begin
      idle(); put(200 + k, 0, 1'b0, 1'b0, 1200 + k); #1;
      chk("fill_tag", add_tag, fill_tags[k]);
      tick();
    end
    idle(); #1;
    chk("fill_full", full, 1'b1);
    chk("fill_count", count, 4'd8);
    put(300, 1, 1'b0, 1'b0, 1300); #1;
    chk("full_nomatch_ack", add_ack, 1'b0);
    put(203, 2, 1'b0, 1'b0, 9); #1;
    chk("full_match_ack", add_ack, 1'b1);
    chk("full_match_tag", add_tag, 3'd5);
    tick(); idle();
    del = 1'b1; del_tag = 3'd3; put(300, 1, 1'b0, 1'b0, 1300); #1;
    chk("del_add_delvalid", del_valid, 1'b1);
    chk("del_add_ack", add_ack, 1'b0);
    tick(); idle(); #1;
    chk("del_add_count", count, 4'd7);
    put(300, 1, 1'b0, 1'b0, 1300); #1;
    chk("retry_ack", add_ack, 1'b1);
    chk("retry_tag", add_tag, 3'd3);
    tick(); idle(); #1;
    chk("retry_count", count, 4'd8);

    // age order among unissued: 0,4,5,6,7,3
    chk("age_rn0", rn_tag, 3'd0);
    read_next = 1'b1; tick(); idle(); #1;
    chk("age_rn1", rn_tag, 3'd4);
    read_next = 1'b1; tick(); idle(); #1;
    chk("age_rn2", rn_tag, 3'd5);
    del = 1'b1; del_tag = 3'd5; read_next = 1'b1; tick(); idle(); get = 1'b1; get_tag = 3'd5; #1;
    chk("delrn_rn_tag", rn_tag, 3'd6);
    chk("delrn_rn_addr", rn_addr, 20'd204);
    chk("delrn_count", count, 4'd7);
    chk("delrn_get_valid", get_valid, 1'b0);
    idle(); del = 1'b1; del_tag = 3'd5; #1;
    chk("del_invalid", del_valid, 1'b0);
    tick(); idle(); #1;
    chk("del_invalid_count", count, 4'd7);

    // frozen when enable is low
    enable = 1'b0; put(400, 0, 1'b0, 1'b0, 1); del = 1'b1; del_tag = 3'd6; read_next = 1'b1; #1;
    chk("frz_ack", add_ack, 1'b0);
    chk("frz_del_valid", del_valid, 1'b0);
    chk("frz_rn_tag", rn_tag, 3'd6);
    tick(); idle(); enable = 1'b1; #1;
    chk("frz_count", count, 4'd7);
    chk("frz_rn_tag_after", rn_tag, 3'd6);

    del = 1'b1; del_tag = 3'd7; tick(); idle(); #1;
    chk("six_count", count, 4'd6);

    // reset mid-operation with a request present
    reset = 1'b1; put(500, 0, 1'b0, 1'b0, 1); read_next = 1'b1;
    tick(); reset = 1'b0; idle(); get = 1'b1; get_tag = 3'd0; #1;
    chk("rst2_empty", empty, 1'b1);
    chk("rst2_count", count, 4'd0);
    chk("rst2_rn_valid", rn_valid, 1'b0);
    chk("rst2_full", full, 1'b0);
    chk("rst2_get_valid", get_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
